// File: rtl/conv_col_writer.sv
// ============================================================================
// Module   : conv_col_writer
// Purpose  : Packs each output column into a low and a high 256-bit memory word.
//            Define COL_WRITER_RELU_EN to clamp negative elements to zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_col_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_COLS   = 24,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  valid_in_col,
    input  logic [5:0]            col_num,
    input  logic [DATA_WIDTH-1:0] data_in_x [OUT_COLS],
    output logic                  in_ready,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [255:0]          data_out,
    output logic                  done,
    output logic                  overflow,
    output logic                  col_err
);

    localparam logic [5:0] c_out_cols = 6'(OUT_COLS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_COL = 3'd1,
        S_WR_LO    = 3'd2,
        S_WR_HI    = 3'd3,
        S_COMPLETE = 3'd4
    } state_t;

    state_t                r_state;
    logic [5:0]            r_count;
    logic [255:0]          r_hi_word;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [255:0]          r_data;
    logic                  r_done;
    logic                  r_overflow;
    logic                  r_col_err;

    logic [DATA_WIDTH-1:0] w_elem [OUT_COLS];
    logic [255:0]          w_lo_word;
    logic [255:0]          w_hi_word;
    logic                  w_col_ok;
    logic                  w_last;
    logic                  w_ready;
    logic                  w_take;
    logic [ADDR_WIDTH-1:0] w_addr_lo;

    generate
        for (genvar k = 0; k < OUT_COLS; k++) begin : g_elem
`ifdef COL_WRITER_RELU_EN
            assign w_elem[k] = data_in_x[k][DATA_WIDTH-1] ? '0 : data_in_x[k];
`else
            assign w_elem[k] = data_in_x[k];
`endif
        end

        for (genvar j = 0; j < 16; j++) begin : g_lane
            if (j < OUT_COLS) begin : g_lo
                assign w_lo_word[j*16 +: 16] = 16'(w_elem[j]);
            end else begin : g_lo_zero
                assign w_lo_word[j*16 +: 16] = 16'd0;
            end
            if (j + 16 < OUT_COLS) begin : g_hi
                assign w_hi_word[j*16 +: 16] = 16'(w_elem[j+16]);
            end else begin : g_hi_zero
                assign w_hi_word[j*16 +: 16] = 16'd0;
            end
        end
    endgenerate

    // The column being written in WR_HI is already counted as the final one when
    // the counter sits at OUT_COLS-1, so no further column may be accepted.
    assign w_col_ok  = (col_num < c_out_cols);
    assign w_last    = (r_count == c_out_cols - 6'd1);
    assign w_ready   = (r_state == S_WAIT_COL) || ((r_state == S_WR_HI) && !w_last);
    assign w_take    = valid_in_col && w_ready;
    assign w_addr_lo = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({col_num, 1'b0});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= 6'd0;
            r_hi_word  <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_col_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_we <= 1'b0;
                    if (start) begin
                        r_state    <= S_WAIT_COL;
                        r_count    <= 6'd0;
                        r_overflow <= 1'b0;
                        r_col_err  <= 1'b0;
                    end
                end
                S_WAIT_COL: begin
                    r_we <= 1'b0;
                    if (w_take) begin
                        if (w_col_ok) begin
                            r_state   <= S_WR_LO;
                            r_we      <= 1'b1;
                            r_addr    <= w_addr_lo;
                            r_data    <= w_lo_word;
                            r_hi_word <= w_hi_word;
                        end else begin
                            r_col_err <= 1'b1;
                        end
                    end
                end
                S_WR_LO: begin
                    r_state <= S_WR_HI;
                    r_we    <= 1'b1;
                    r_addr  <= r_addr + 1'b1;
                    r_data  <= r_hi_word;
                    if (valid_in_col) begin
                        r_overflow <= 1'b1;
                    end
                end
                S_WR_HI: begin
                    r_count <= r_count + 6'd1;
                    if (w_last) begin
                        r_state <= S_COMPLETE;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        if (valid_in_col) begin
                            r_overflow <= 1'b1;
                        end
                    end else if (w_take && w_col_ok) begin
                        r_state   <= S_WR_LO;
                        r_we      <= 1'b1;
                        r_addr    <= w_addr_lo;
                        r_data    <= w_lo_word;
                        r_hi_word <= w_hi_word;
                    end else begin
                        r_state <= S_WAIT_COL;
                        r_we    <= 1'b0;
                        if (w_take) begin
                            r_col_err <= 1'b1;
                        end
                    end
                end
                S_COMPLETE: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                    if (valid_in_col) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = w_ready;
    assign write_enable = r_we;
    assign addr         = r_addr;
    assign data_out     = r_data;
    assign done         = r_done;
    assign overflow     = r_overflow;
    assign col_err      = r_col_err;

endmodule

`default_nettype wire

// File: doc/conv_col_writer.md
CONV_COL_WRITER -- requirements
Module: conv_col_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, fp16 element width.
REQ-002 SHALL have parameter OUT_COLS, default 24, elements per column and columns per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first memory word address of the frame.
REQ-004 SHALL have parameter ADDR_WIDTH, default 12, memory address width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle pulse arming a frame.
REQ-008 SHALL have port valid_in_col  input  1  column present on data_in_x/col_num.
REQ-009 SHALL have port col_num  input  6  output column index, 0..OUT_COLS-1.
REQ-010 SHALL have port data_in_x  input  DATA_WIDTH x OUT_COLS (unpacked)  column elements, index 0 = top row.
REQ-011 SHALL have port in_ready  output  1  column accepted on edge where valid_in_col && in_ready.
REQ-012 SHALL have port write_enable  output  1  memory write strobe, registered.
REQ-013 SHALL have port addr  output  ADDR_WIDTH  memory word address, registered.
REQ-014 SHALL have port data_out  output  256  memory write word, 16 lanes, lane j at bits [j*16 +: 16], registered.
REQ-015 SHALL have port done  output  1  one-cycle pulse, frame complete.
REQ-016 SHALL have port overflow  output  1  sticky: column dropped while not ready.
REQ-017 SHALL have port col_err  output  1  sticky: col_num >= OUT_COLS received.

Function
REQ-018 SHALL implement states IDLE, WAIT_COL, WR_LO, WR_HI, COMPLETE.
REQ-019 SHALL go IDLE -> WAIT_COL on start, clearing column counter, overflow, col_err; start in any other state is ignored.
REQ-020 SHALL assert in_ready only in WAIT_COL and WR_HI.
REQ-021 SHALL, on acceptance, latch elements and col_num and enter WR_LO next cycle.
REQ-022 SHALL in WR_LO drive write_enable=1, addr=BASE_ADDR+2*col_num, data_out lanes 0..15 = elements 0..15.
REQ-023 SHALL in WR_HI drive write_enable=1, addr=BASE_ADDR+2*col_num+1, lanes 0..7 = elements 16..23, lanes 8..15 = 0.
REQ-024 SHALL drive write_enable=0 and hold addr/data_out in all other states.
REQ-025 SHALL give latency: accepted at edge N -> low word during cycle N+1, high word during N+2; sustained throughput one column per 2 cycles.
REQ-026 SHALL increment the written-column counter at end of each WR_HI.
REQ-027 SHALL leave WR_HI for COMPLETE when the counter reaches OUT_COLS, else WR_LO if a new column accepted that cycle, else WAIT_COL.
REQ-028 SHALL deassert in_ready in the WR_HI cycle that writes the final column.
REQ-029 SHALL pulse done for exactly one cycle in COMPLETE, then return to IDLE.
REQ-030 SHALL, on a column with col_num >= OUT_COLS, set col_err, perform no write, not count it, stay in WAIT_COL.
REQ-031 SHALL set overflow on valid_in_col && !in_ready in WR_LO, WR_HI-final or COMPLETE; column dropped.
REQ-032 SHALL ignore valid_in_col in IDLE without setting flags.
REQ-033 SHALL write duplicate col_num values again (last write wins) and count each.

Reset
REQ-034 SHALL on rst: state IDLE, counter 0, in_ready 0, write_enable 0, addr 0, data_out 0, done 0, overflow 0, col_err 0.
REQ-035 SHALL abort any frame on rst mid-operation with no further writes; new start required.

Configuration
REQ-036 SHALL, with COL_WRITER_RELU_EN defined, replace every element with sign bit 1 (including -0) by 16'h0000 before packing.
REQ-037 SHALL, without COL_WRITER_RELU_EN, pack elements bit-exact.

Verification
REQ-038 SHALL cover: start, one column col_num=3, element k=16'h3C00+k -> addr 6 lanes 0..15 = 3C00..3C0F, next cycle addr 7 lanes 0..7 = 3C10..3C17, upper lanes 0.
REQ-039 SHALL cover: 24 columns back-to-back every 2 cycles, col 0..23 -> 48 writes addr 0..47 contiguous, done one cycle after addr 47, overflow 0.
REQ-040 SHALL cover: valid_in_col held during WR_LO -> overflow=1, that column not written.
REQ-041 SHALL cover: col_num=24 -> col_err=1, no write_enable, counter unchanged.
REQ-042 SHALL cover: rst asserted after 5 columns -> outputs zero next cycle, no writes until new start.
REQ-043 SHALL cover: element 16'hC000 and 16'h8000 -> written as 0000 with COL_WRITER_RELU_EN, as C000/8000 without.
